hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the LEGv8 in-order pipeline. It sits beside the decode stage.
- It tracks the destination register of every in-flight instruction through DEPTH post-decode stages (default: EX, MEM, WB).
- Outputs:
  - a load-use stall that freezes fetch and decode and injects a bubble;
  - per-operand forwarding selects consumed by the execute stage.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard_pkg.sv | 14 +
 rtl/scoreboard_slot.sv | 39 +++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and match helper for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int FWD_RF       = 0;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_ZERO_REG = 31;

  // A slot supplies a source only if it is live, writes a register, and that register is rs.
  function automatic logic slot_match(input logic used, input logic rs_zero,
                                      input logic v, input logic rw, input logic rd_eq);
    return used && !rs_zero && v && rw && rd_eq;
  endfunction

endpackage

// File: rtl/scoreboard_slot.sv
// rtl/scoreboard_slot.sv - one in-flight {v, rd, rw, ld} register with load-or-bubble input
module scoreboard_slot
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take,
  input  logic              in_v,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rw,
  input  logic              in_ld,
  output logic              v,
  output logic [REG_AW-1:0] rd,
  output logic              rw,
  output logic              ld
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v  <= 1'b0;
      rd <= '0;
      rw <= 1'b0;
      ld <= 1'b0;
    end else if (take) begin
      v  <= in_v;
      rd <= in_rd;
      rw <= in_rw;
      ld <= in_ld;
    end else begin
      v  <= 1'b0;
      rd <= '0;
      rw <= 1'b0;
      ld <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use stall and forwarding-select controller beside decode
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH            = 3,
  parameter int REG_AW           = DEF_REG_AW,
  parameter int ZERO_REG         = DEF_ZERO_REG,
  parameter int LOAD_READY       = 2,
  parameter int WB_WRITE_THROUGH = 1,
  parameter int CNT_W            = 16,
  parameter int FWD_W            = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_reg_write,
  input  logic              issue_mem_read,
  input  logic [REG_AW-1:0] rs1,
  input  logic              rs1_used,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs2_used,
  input  logic              flush,
  output logic              stall,
  output logic [FWD_W-1:0]  fwd_sel1,
  output logic [FWD_W-1:0]  fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The WB slot is invisible to matching when the register file writes before it is read.
  localparam int MATCH_TOP = (WB_WRITE_THROUGH != 0) ? DEPTH - 1 : DEPTH;
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [DEPTH:1]    slot_v, slot_rw, slot_ld;
  logic [REG_AW-1:0] slot_rd [1:DEPTH];
  logic [DEPTH:1]    m1, m2;
  logic              hazard_any;
  logic              issue_take;

  assign issue_take = issue_valid && !stall && !flush;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_slot
    if (k == 1) begin : g_head
      scoreboard_slot #(.REG_AW(REG_AW)) u_slot (
        .clk(clk), .reset_n(reset_n), .take(issue_take),
        .in_v(1'b1), .in_rd(issue_rd), .in_rw(issue_reg_write), .in_ld(issue_mem_read),
        .v(slot_v[k]), .rd(slot_rd[k]), .rw(slot_rw[k]), .ld(slot_ld[k])
      );
    end else begin : g_tail
      scoreboard_slot #(.REG_AW(REG_AW)) u_slot (
        .clk(clk), .reset_n(reset_n), .take(1'b1),
        .in_v(slot_v[k-1]), .in_rd(slot_rd[k-1]), .in_rw(slot_rw[k-1]), .in_ld(slot_ld[k-1]),
        .v(slot_v[k]), .rd(slot_rd[k]), .rw(slot_rw[k]), .ld(slot_ld[k])
      );
    end
  end

  always_comb begin
    m1         = '0;
    m2         = '0;
    hazard_any = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k <= MATCH_TOP) begin
        m1[k] = slot_match(rs1_used, rs1 == ZR, slot_v[k], slot_rw[k], slot_rd[k] == rs1);
        m2[k] = slot_match(rs2_used, rs2 == ZR, slot_v[k], slot_rw[k], slot_rd[k] == rs2);
      end
      if (k < LOAD_READY && slot_ld[k] && (m1[k] || m2[k])) hazard_any = 1'b1;
    end
  end

  assign stall = issue_valid && hazard_any && !flush;

  // Scan oldest to youngest so the youngest producer overwrites the select last.
  always_comb begin
    fwd_sel1 = FWD_W'(FWD_RF);
    fwd_sel2 = FWD_W'(FWD_RF);
    for (int k = DEPTH; k >= 1; k--) begin
      if (m1[k]) fwd_sel1 = FWD_W'(k);
      if (m2[k]) fwd_sel2 = FWD_W'(k);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard in three parameter builds
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iv0, iv1, iv2;
  logic [4:0] rd, rs1, rs2;
  logic       rw, ld, u1, u2, flush;

  logic        st0, st1, st2;
  logic [1:0]  f10, f20;
  logic [2:0]  f11, f21, f12, f22;
  logic [15:0] c0, c1, c2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    inst;
    string nm;
    int    st;
    int    f1;
    int    f2;
    int    cnt;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   a_st, a_f1, a_f2, a_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard u_d3 (
    .clk(clk), .reset_n(reset_n), .issue_valid(iv0), .issue_rd(rd),
    .issue_reg_write(rw), .issue_mem_read(ld), .rs1(rs1), .rs1_used(u1),
    .rs2(rs2), .rs2_used(u2), .flush(flush), .stall(st0),
    .fwd_sel1(f10), .fwd_sel2(f20), .stall_cnt(c0)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_READY(3)) u_d4 (
    .clk(clk), .reset_n(reset_n), .issue_valid(iv1), .issue_rd(rd),
    .issue_reg_write(rw), .issue_mem_read(ld), .rs1(rs1), .rs1_used(u1),
    .rs2(rs2), .rs2_used(u2), .flush(flush), .stall(st1),
    .fwd_sel1(f11), .fwd_sel2(f21), .stall_cnt(c1)
  );

  hazard_scoreboard #(.DEPTH(6), .LOAD_READY(6)) u_d6 (
    .clk(clk), .reset_n(reset_n), .issue_valid(iv2), .issue_rd(rd),
    .issue_reg_write(rw), .issue_mem_read(ld), .rs1(rs1), .rs1_used(u1),
    .rs2(rs2), .rs2_used(u2), .flush(flush), .stall(st2),
    .fwd_sel1(f12), .fwd_sel2(f22), .stall_cnt(c2)
  );

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    if (req >= 0) begin
      checks++;
      if (act != req) begin
        errors++;
        $display("FAIL %s.%s actual %0d required %0d", nm, fld, act, req);
      end
    end
  endtask

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        me = q.pop_front();
        case (me.inst)
          0:       begin a_st = int'(st0); a_f1 = int'(f10); a_f2 = int'(f20); a_cnt = int'(c0); end
          1:       begin a_st = int'(st1); a_f1 = int'(f11); a_f2 = int'(f21); a_cnt = int'(c1); end
          default: begin a_st = int'(st2); a_f1 = int'(f12); a_f2 = int'(f22); a_cnt = int'(c2); end
        endcase
        cmp(me.nm, "stall", a_st, me.st);
        cmp(me.nm, "fwd_sel1", a_f1, me.f1);
        cmp(me.nm, "fwd_sel2", a_f2, me.f2);
        cmp(me.nm, "stall_cnt", a_cnt, me.cnt);
      end
    end
  end

  task automatic expect_out(input int inst, input string nm, input int st, input int f1,
                            input int f2, input int cnt);
    exp_t e;
    e.inst = inst; e.nm = nm; e.st = st; e.f1 = f1; e.f2 = f2; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drive(input int inst, input logic v, input logic [4:0] rd_i, input logic rw_i,
                       input logic ld_i, input logic [4:0] r1, input logic u1_i,
                       input logic [4:0] r2, input logic u2_i, input logic fl);
    iv0 = v && (inst == 0);
    iv1 = v && (inst == 1);
    iv2 = v && (inst == 2);
    rd = rd_i; rw = rw_i; ld = ld_i;
    rs1 = r1; u1 = u1_i; rs2 = r2; u2 = u2_i; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #7;
    expect_out(0, "rst_d3", 0, 0, 0, 0);
    expect_out(1, "rst_d4", 0, 0, 0, 0);
    expect_out(2, "rst_d6", 0, 0, 0, 0);
    tick;
    reset_n = 1'b1;

    // load X2 then ADD X3, X2, X4
    tick; drive(0, 1, 2, 1, 1, 0, 0, 0, 0, 0); expect_out(0, "t1_load", 0, 0, 0, 0);
    tick; drive(0, 1, 3, 1, 0, 2, 1, 4, 1, 0); expect_out(0, "t1_stall", 1, 1, 0, 0);
    tick;                                      expect_out(0, "t1_fwd", 0, 2, 0, 1);

    // ALU chain through X5
    tick; drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); expect_out(0, "t2_add", 0, 0, 0, 1);
    tick; drive(0, 1, 6, 1, 0, 5, 1, 5, 1, 0); expect_out(0, "t2_sub", 0, 1, 1, 1);
    tick; drive(0, 1, 9, 1, 0, 5, 1, 9, 1, 0); expect_out(0, "t2_gap", 0, 2, 0, 1);

    // XZR and non-writing producers
    tick; drive(0, 1, 31, 1, 1, 0, 0, 0, 0, 0); expect_out(0, "t3_wzr", 0, 0, 0, -1);
    tick; drive(0, 1, 0, 0, 0, 31, 1, 31, 1, 0); expect_out(0, "t3_rzr", 0, 0, 0, 1);
    tick; drive(0, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    tick; drive(0, 1, 0, 0, 0, 8, 1, 8, 1, 0); expect_out(0, "t3_norw", 0, 0, 0, 1);

    // flush beats stall
    tick; drive(0, 1, 7, 1, 1, 0, 0, 0, 0, 0);
    tick; drive(0, 1, 0, 0, 0, 7, 1, 7, 1, 1); expect_out(0, "t4_flush", 0, 1, 1, 1);
    tick; drive(0, 1, 0, 0, 0, 7, 1, 0, 0, 0); expect_out(0, "t4_after", 0, 2, 0, 1);

    // asynchronous reset with three live slots
    tick; drive(0, 1, 10, 1, 0, 0, 0, 0, 0, 0);
    tick; drive(0, 1, 11, 1, 0, 0, 0, 0, 0, 0);
    tick; drive(0, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    tick; drive(0, 1, 0, 0, 0, 11, 1, 12, 1, 0); expect_out(0, "t5_pre", 0, 2, 1, 1);
    tick; reset_n = 1'b0;                        expect_out(0, "t5_rst", 0, 0, 0, 0);
    tick; reset_n = 1'b1;
    drive(0, 1, 0, 0, 0, 12, 1, 11, 1, 0);       expect_out(0, "t5_post", 0, 0, 0, 0);

    // DEPTH=4, LOAD_READY=3: two stall cycles
    tick; drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0); expect_out(1, "t6_load", 0, 0, 0, 0);
    tick; drive(1, 1, 3, 1, 0, 2, 1, 0, 0, 0); expect_out(1, "t6_s1", 1, 1, 0, 0);
    tick;                                      expect_out(1, "t6_s2", 1, 2, 0, 1);
    tick;                                      expect_out(1, "t6_fwd", 0, 3, 0, 2);

    // self-dependent load stalls five of every six cycles until the counter saturates
    tick; drive(2, 1, 1, 1, 1, 1, 1, 0, 0, 0); expect_out(2, "sat_c0", 0, 0, 0, 0);
    tick;                                      expect_out(2, "sat_c1", 1, 1, 0, 0);
    repeat (80000) tick;
    expect_out(2, "sat_full", -1, -1, -1, 65535);
    repeat (7) tick;
    expect_out(2, "sat_hold", -1, -1, -1, 65535);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
